btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Front-end stage that sits directly upstream of the calculator top.
- Takes raw board pushbuttons btnl, btnc, btnr, btnd and switches sw[15:0].
- Synchronizes them to clk, debounces the buttons, and drives the calculator's op-select levels, its one-cycle "enter" strobe and a synchronized switch bus.
- btnu is not conditioned here; it is this block's reset, and the top also routes it straight to the calculator.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer chain (>=2).
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from its stable value before the stable value flips (>=1). Benches use 4.
- REPEAT_CYCLES, 64, auto-repeat period; used only when AUTOREPEAT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- btnu  in  1  reset; synchronous, active-high.
- btnl_raw  in  1  raw left button.
- btnc_raw  in  1  raw centre button.
- btnr_raw  in  1  raw right button.
- btnd_raw  in  1  raw down (enter) button.
- sw_raw  in  16  raw switches.
- btnl  out  1  debounced level.
- btnc  out  1  debounced level.
- btnr  out  1  debounced level.
- btnd  out  1  one-cycle pulse per debounced press of btnd_raw.
- sw  out  16  synchronized switches.

Behaviour:
- Reset (btnu=1 at a rising edge):
  - all sync flops, counters and stable values go to 0.
  - btnl, btnc, btnr, btnd all 0; sw = 16'h0000.
  - Reset has priority over every other event.
  - Reset mid-count discards the partial count; a button held through reset release is re-qualified from zero (full latency again).
- Synchronizer: each input passes through SYNC_STAGES flops. With SYNC_STAGES=2, sw follows sw_raw 2 edges later. sw is not debounced.
- Debounce, per button; state is stable (1 bit) and cnt (width clog2(DEBOUNCE_CYCLES), min 1):
  - sync == stable: cnt <= 0.
  - sync != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - Any glitch back to stable clears cnt, so bounces shorter than DEBOUNCE_CYCLES never propagate.
- Latency: a raw level held from before edge 1 reaches the stable output at edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6 for 2/4).
- btnl, btnc, btnr outputs equal their stable bits (registered).
- btnd pulse:
  - Goes high at the same edge btnd's stable flips 0->1, and low at the next edge (exactly 1 cycle).
  - No pulse on release.
  - Holding the button produces no further pulses (unless AUTOREPEAT_EN).
- Simultaneous events:
  - Buttons are fully independent; several may qualify on the same edge.
  - op levels and the btnd pulse updating on the same edge is legal.
  - The calculator samples the op levels together with the pulse, so op buttons must be qualified before btnd.
- No wrap: cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - while btnd's stable bit stays 1, a repeat counter runs from the press edge.
  - An additional 1-cycle btnd pulse is issued every REPEAT_CYCLES cycles after the initial pulse.
  - The counter clears on release or reset.
- Undefined: exactly one pulse per press; repeat counter and REPEAT_CYCLES logic absent.

Decomposition:
- Shared package btn_pkg holds:
  - default constants SYNC_STAGES_DEF, DEBOUNCE_CYCLES_DEF, REPEAT_CYCLES_DEF.
  - the button index enum BTN_L, BTN_C, BTN_R, BTN_D.
- Natural sub-module btn_debounce: one button's synchronizer, counter and stable register, plus a rise output.
  - Instantiated 4 times.
  - btnd pulse and auto-repeat logic live in the top.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
1. Clean press: btnu=1 for 1 edge, then btnd_raw=1 held from edge 1 -> btnd=1 only in the cycle after edge 6, 0 afterwards; btnl/btnc/btnr stay 0.
2. Bounce reject: btnd_raw toggles every 2 cycles for 12 cycles, then 0 -> btnd never asserts; stable stays 0.
3. Op levels: btnl_raw=1, btnr_raw=1 from edge 1, btnd_raw=1 from edge 8 -> btnl=btnr=1 from edge 6; single btnd pulse at edge 13 with btnl=btnr=1, btnc=0.
4. Switches: sw_raw=16'h354a at edge 1, 16'h1234 at edge 5 -> sw=16'h354a from edge 2, 16'h1234 from edge 6.
5. Reset mid-operation: btnc_raw=1 from edge 1, btnu=1 at edge 4 only -> btnc=0 through edge 4; btnc rises at edge 10 (full re-qualification); sw=0 after edge 4 until resynced.
6. Auto-repeat (BTN_AUTOREPEAT_EN): btnd_raw held 30 cycles -> pulses at edges 6, 14, 22, 30; without the macro only at edge 6.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared defaults, button indices and counter-width helper for btn_conditioner
package btn_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_CYCLES_DEF = 64;
  typedef enum logic [1:0] {BTN_L = 2'd0, BTN_C = 2'd1, BTN_R = 2'd2, BTN_D = 2'd3} btn_idx_e;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button's synchronizer, debounce counter and stable level, with a rise strobe
module btn_debounce
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic sync, flip;
  assign sync = sync_q[SYNC_STAGES-1];
  assign flip = (sync != stable) && (cnt == CMAX);
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt <= '0;
      stable <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt <= (sync == stable || flip) ? '0 : cnt + 1'b1;
      stable <= flip ? sync : stable;
      rise <= flip && sync;
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: syncs/debounces buttons, strobes enter on btnd press, syncs switches
// Define BTN_AUTOREPEAT_EN to re-strobe btnd every REPEAT_CYCLES while it is held.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        btnu,
  input  logic        btnl_raw,
  input  logic        btnc_raw,
  input  logic        btnr_raw,
  input  logic        btnd_raw,
  input  logic [15:0] sw_raw,
  output logic        btnl,
  output logic        btnc,
  output logic        btnr,
  output logic        btnd,
  output logic [15:0] sw
);
  logic [3:0] raw, stable, rise;
  logic [15:0] sw_q [SYNC_STAGES];
  assign raw = {btnd_raw, btnr_raw, btnc_raw, btnl_raw};
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst(btnu), .raw(raw[i]), .stable(stable[i]), .rise(rise[i])
    );
  end
  always_ff @(posedge clk) begin
    if (btnu) begin
      for (int k = 0; k < SYNC_STAGES; k++) sw_q[k] <= '0;
    end else begin
      sw_q[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sw_q[k] <= sw_q[k-1];
    end
  end
  assign sw = sw_q[SYNC_STAGES-1];
  assign btnl = stable[BTN_L];
  assign btnc = stable[BTN_C];
  assign btnr = stable[BTN_R];
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt;
  logic rep;
  // counter starts from zero on the press edge since it is held clear while released
  always_ff @(posedge clk) begin
    if (btnu) begin
      rcnt <= '0;
      rep <= 1'b0;
    end else begin
      rcnt <= (!stable[BTN_D] || rcnt == RMAX) ? '0 : rcnt + 1'b1;
      rep <= stable[BTN_D] && rcnt == RMAX;
    end
  end
  assign btnd = rise[BTN_D] | rep;
  logic unused_ok;
  assign unused_ok = &{1'b0, rise[2:0]};
`else
  assign btnd = rise[BTN_D];
  logic unused_ok;
  assign unused_ok = &{1'b0, rise[2:0], stable[BTN_D]};
`endif
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of btn_conditioner with SYNC=2, DEBOUNCE=4, REPEAT=8
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic btnu = 1'b0;
  logic btnl_raw = 1'b0, btnc_raw = 1'b0, btnr_raw = 1'b0, btnd_raw = 1'b0;
  logic [15:0] sw_raw = '0;
  logic btnl, btnc, btnr, btnd;
  logic [15:0] sw;
  int nerr = 0;
  int nchk = 0;

  btn_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .btnu(btnu), .btnl_raw(btnl_raw), .btnc_raw(btnc_raw), .btnr_raw(btnr_raw),
    .btnd_raw(btnd_raw), .sw_raw(sw_raw), .btnl(btnl), .btnc(btnc), .btnr(btnr), .btnd(btnd), .sw(sw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {btnl_raw, btnc_raw, btnr_raw, btnd_raw} = '0;
    sw_raw = '0;
    btnu = 1'b1;
    tick();
    btnu = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_btnl", 32'(btnl), 0);
    chk("rst_btnc", 32'(btnc), 0);
    chk("rst_btnr", 32'(btnr), 0);
    chk("rst_btnd", 32'(btnd), 0);
    chk("rst_sw", 32'(sw), 0);
    // 1: clean press
    btnd_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("t1_btnd_e%0d", e), 32'(btnd), 32'(e == 6));
      chk($sformatf("t1_ops_e%0d", e), 32'({btnl, btnc, btnr}), 0);
    end
    // 2: bounce reject
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      btnd_raw = (e <= 12) && (((e - 1) / 2) % 2 == 0);
      tick();
      chk($sformatf("t2_btnd_e%0d", e), 32'(btnd), 0);
    end
    // 3: op levels qualified before enter
    do_reset();
    btnl_raw = 1'b1;
    btnr_raw = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      if (e == 8) btnd_raw = 1'b1;
      tick();
      chk($sformatf("t3_btnl_e%0d", e), 32'(btnl), 32'(e >= 6));
      chk($sformatf("t3_btnr_e%0d", e), 32'(btnr), 32'(e >= 6));
      chk($sformatf("t3_btnc_e%0d", e), 32'(btnc), 0);
      chk($sformatf("t3_btnd_e%0d", e), 32'(btnd), 32'(e == 13));
    end
    // 4: switches
    do_reset();
    sw_raw = 16'h354a;
    for (int e = 1; e <= 8; e++) begin
      if (e == 5) sw_raw = 16'h1234;
      tick();
      chk($sformatf("t4_sw_e%0d", e), 32'(sw), (e >= 6) ? 32'h1234 : (e >= 2) ? 32'h354a : 32'h0);
    end
    // 5: reset mid-count
    do_reset();
    btnc_raw = 1'b1;
    sw_raw = 16'hffff;
    for (int e = 1; e <= 12; e++) begin
      btnu = (e == 4);
      tick();
      chk($sformatf("t5_btnc_e%0d", e), 32'(btnc), 32'(e >= 10));
      chk($sformatf("t5_sw_e%0d", e), 32'(sw), (e == 1 || e == 4 || e == 5) ? 32'h0 : 32'hffff);
    end
    btnu = 1'b0;
    // 6: long hold
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      btnd_raw = (e <= 30);
      tick();
`ifdef BTN_AUTOREPEAT_EN
      chk($sformatf("t6_btnd_e%0d", e), 32'(btnd), 32'(e == 6 || e == 14 || e == 22 || e == 30));
`else
      chk($sformatf("t6_btnd_e%0d", e), 32'(btnd), 32'(e == 6));
`endif
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
